// File: rtl/popcount_pkg.sv
// popcount_pkg: shared helpers for the pipelined population counter.
//   clog2_ceil(n)      - ceil(log2(n)), 0 for n <= 1
//   cnt_w(n)           - width needed to hold a count of 0..n
//   lvl_w/lvl_off      - width and offset of each tree level in the packed tree vector
//   sat_add(acc,inc,w) - w-bit saturating add; bit 64 of the result flags a clamp
package popcount_pkg;

    function automatic int unsigned clog2_ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return clog2_ceil(n + 1);
    endfunction

    // Level 0 is the padded input (one bit per leaf); level k holds 2^(lvl-k)
    // sums of k+1 bits, except the last level which is cut to the count width.
    function automatic int unsigned lvl_w(input int unsigned lvl, input int unsigned cw,
                                          input int unsigned k);
        if (k == 0) return 32'd1 << lvl;
        if (k == lvl) return cw;
        return (32'd1 << (lvl - k)) * (k + 1);
    endfunction

    function automatic int unsigned lvl_off(input int unsigned lvl, input int unsigned cw,
                                            input int unsigned k);
        int unsigned o;
        o = 0;
        for (int unsigned j = 0; j < k; j++) o += lvl_w(lvl, cw, j);
        return o;
    endfunction

    function automatic logic [64:0] sat_add(input logic [63:0] acc, input logic [63:0] inc,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << w) - 65'd1;
        if (sum > lim) return {1'b1, lim[63:0]};
        return {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/popcount_pipe_level.sv
// popcount_level: one registered adder-tree level.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   adv_i          - pipeline advance enable; when low data and valid hold
//   valid_i/data_i - previous level: 2*PAIRS operands of IW bits each
//   valid_o/data_o - PAIRS registered sums of OW bits each (OW >= IW)
module popcount_level #(
    parameter int unsigned PAIRS = 1,
    parameter int unsigned IW    = 1,
    parameter int unsigned OW    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  adv_i,
    input  logic                  valid_i,
    input  logic [2*PAIRS*IW-1:0] data_i,
    output logic                  valid_o,
    output logic [PAIRS*OW-1:0]   data_o
);

    logic [PAIRS*OW-1:0] sum_d;
    logic [PAIRS*OW-1:0] sum_q;
    logic                valid_q;

    always_comb begin
        sum_d = '0;
        for (int unsigned p = 0; p < PAIRS; p++) begin
            sum_d[p*OW +: OW] = OW'(data_i[2*p*IW +: IW]) + OW'(data_i[(2*p+1)*IW +: IW]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            sum_q   <= sum_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = sum_q;

endmodule

// File: rtl/popcount_pipe.sv
// popcount_pipe: fully pipelined population counter with valid/ready flow
// control and a saturating running accumulator of delivered counts.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - input handshake; in_ready = ~out_valid | out_ready
//   in_data              - N_IN-bit word to count
//   out_valid/out_ready  - output handshake
//   out_count            - number of ones in the beat (CW bits)
//   acc_clr              - clear accumulator (a coinciding transfer loads its count)
//   acc_total, acc_sat   - saturating sum of transferred counts, sticky clamp flag
// Optional (macro POPCOUNT_THRESH_EN): thresh input, out_hit = out_count >= thresh.
module popcount_pipe
    import popcount_pkg::*;
#(
    parameter int unsigned N_IN  = 16,
    parameter int unsigned CW    = cnt_w(N_IN),
    parameter int unsigned ACC_W = 16,
    parameter int unsigned LVL   = clog2_ceil(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc_total,
    output logic             acc_sat
`ifdef POPCOUNT_THRESH_EN
    ,
    input  logic [CW-1:0]    thresh,
    output logic             out_hit
`endif
);

    localparam int unsigned NP      = 32'd1 << LVL;
    localparam int unsigned TW      = lvl_off(LVL, CW, LVL + 1);
    localparam int unsigned OUT_OFF = lvl_off(LVL, CW, LVL);

    // All tree levels packed back to back; level k lives at lvl_off(k).
    logic [TW-1:0]   tree;
    logic [LVL:0]    vld;
    logic            adv;
    logic            xfer;

    logic [N_IN-1:0] s0_data_q;
    logic            s0_valid_q;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign xfer     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
        end else if (adv) begin
            s0_valid_q <= in_valid;
            s0_data_q  <= in_data;
        end
    end

    assign vld[0]           = s0_valid_q;
    assign tree[N_IN-1:0]   = s0_data_q;
    if (NP > N_IN) begin : g_pad
        assign tree[NP-1:N_IN] = '0;
    end

    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int unsigned PAIRS = NP >> k;
        localparam int unsigned OWD   = (k == LVL) ? CW : k + 1;
        popcount_level #(
            .PAIRS(PAIRS),
            .IW   (k),
            .OW   (OWD)
        ) u_level (
            .clk_i  (clk),
            .rst_i  (rst),
            .adv_i  (adv),
            .valid_i(vld[k-1]),
            .data_i (tree[lvl_off(LVL, CW, k-1) +: lvl_w(LVL, CW, k-1)]),
            .valid_o(vld[k]),
            .data_o (tree[lvl_off(LVL, CW, k) +: lvl_w(LVL, CW, k)])
        );
    end

    assign out_valid = vld[LVL];
    assign out_count = tree[OUT_OFF +: CW];

    logic [ACC_W-1:0] acc_d, acc_q;
    logic             sat_d, sat_q;
    logic [64:0]      sat_res;

    always_comb begin
        sat_res = sat_add(64'(acc_q), 64'(out_count), ACC_W);
        acc_d   = acc_q;
        sat_d   = sat_q;
        if (acc_clr) begin
            acc_d = xfer ? ACC_W'(out_count) : '0;
            sat_d = 1'b0;
        end else if (xfer) begin
            acc_d = ACC_W'(sat_res);
            sat_d = sat_q | sat_res[64];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc_total = acc_q;
    assign acc_sat   = sat_q;

`ifdef POPCOUNT_THRESH_EN
    assign out_hit = out_valid & (out_count >= thresh);
`endif

endmodule
